// File: rtl/riscv_defs.sv
// Shared definitions for the register-file writeback arbiter: FSM encoding and
// the default forced-grant wait limit.
package riscv_defs;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_STALL
  } arb_state_e;

  localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/rf_wb_fifo.sv
// Multi-cycle result buffer: circular FIFO of {addr, data} entries with a per-entry
// valid vector exported for the source-operand pending compare.
module rf_wb_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_push,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_pop,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic [ADDR_WIDTH-1:0]         o_head_addr,
  output logic [DATA_WIDTH-1:0]         o_head_data,
  output logic [DEPTH-1:0]              o_entry_valid,
  output logic [DEPTH*ADDR_WIDTH-1:0]   o_entry_addr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]       r_count, w_count_d;
  logic [DEPTH-1:0]      r_valid, w_valid_d;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic                  w_do_push, w_do_pop;

  assign o_full    = (r_count == CntW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_comb begin
    w_valid_d = r_valid;
    w_count_d = r_count;
    if (w_do_pop)  w_valid_d[r_rd_ptr] = 1'b0;
    if (w_do_push) w_valid_d[r_wr_ptr] = 1'b1;
    if (w_do_push && !w_do_pop)      w_count_d = r_count + CntW'(1);
    else if (!w_do_push && w_do_pop) w_count_d = r_count - CntW'(1);
  end

  // Pointers are PtrW bits wide, so increments wrap modulo DEPTH for free.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= w_count_d;
      r_valid <= w_valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_addr[r_wr_ptr] <= i_addr;
      r_data[r_wr_ptr] <= i_data;
    end
  end

  assign o_count       = r_count;
  assign o_head_addr   = r_addr[r_rd_ptr];
  assign o_head_data   = r_data[r_rd_ptr];
  assign o_entry_valid = r_valid;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign o_entry_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = r_addr[g];
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter between pipeline writeback and buffered multi-cycle results.
// Define RF_WB_ARB_STARVE_EN to add the starvation counter and one-cycle forced-grant STALL.
module rf_wb_arbiter
  import riscv_defs::*;
#(
  parameter int unsigned REGISTER_WIDTH      = 32,
  parameter int unsigned REGISTER_ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH          = 2,
  parameter int unsigned STARVE_LIMIT        = DEFAULT_STARVE_LIMIT
) (
  input  logic                           cpu_clk,
  input  logic                           cpu_rst,
  input  logic                           pipe_we,
  input  logic [REGISTER_ADDR_WIDTH-1:0] pipe_addr,
  input  logic [REGISTER_WIDTH-1:0]      pipe_data,
  input  logic                           mc_valid,
  output logic                           mc_ready,
  input  logic [REGISTER_ADDR_WIDTH-1:0] mc_addr,
  input  logic [REGISTER_WIDTH-1:0]      mc_data,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REGISTER_ADDR_WIDTH-1:0] rs2_addr,
  output logic                           rs1_pending,
  output logic                           rs2_pending,
  output logic                           pipe_stall,
  output logic                           we,
  output logic [REGISTER_ADDR_WIDTH-1:0] wd_addr,
  output logic [REGISTER_WIDTH-1:0]      wd_data,
  output logic                           waw_err
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AW   = REGISTER_ADDR_WIDTH;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..15");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  arb_state_e                r_state, w_state_d;
  logic                      r_waw_err;
  logic                      w_full, w_empty, w_push, w_pop, w_last_pop;
  logic                      w_pipe_wr, w_grant_pipe, w_grant_head, w_pipe_hit;
  logic [CntW-1:0]           w_count;
  logic [AW-1:0]             w_head_addr;
  logic [REGISTER_WIDTH-1:0] w_head_data;
  logic [FIFO_DEPTH-1:0]     w_entry_valid;
  logic [FIFO_DEPTH*AW-1:0]  w_entry_addr;

`ifdef RF_WB_ARB_STARVE_EN
  localparam logic [3:0] LimitCnt = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt, w_starve_cnt_d;
`endif

  rf_wb_fifo #(
    .DATA_WIDTH(REGISTER_WIDTH),
    .ADDR_WIDTH(AW),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .i_clk        (cpu_clk),
    .i_rst        (cpu_rst),
    .i_push       (w_push),
    .i_addr       (mc_addr),
    .i_data       (mc_data),
    .i_pop        (w_pop),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_entry_valid(w_entry_valid),
    .o_entry_addr (w_entry_addr)
  );

  // Address-zero results are accepted but dropped: x0 is never written.
  assign mc_ready   = ~w_full;
  assign w_push     = mc_valid & mc_ready & (mc_addr != '0);
  assign w_pipe_wr  = pipe_we & (pipe_addr != '0);
  assign w_pop      = w_grant_head;
  assign w_last_pop = w_pop & ~w_push & (w_count == CntW'(1));
  assign waw_err    = r_waw_err;

  always_comb begin
    w_grant_pipe = 1'b0;
    w_grant_head = 1'b0;
    pipe_stall   = 1'b0;
`ifdef RF_WB_ARB_STARVE_EN
    if (r_state == ARB_STALL) begin
      pipe_stall   = 1'b1;
      w_grant_head = ~w_empty;
    end else
`endif
    if (w_pipe_wr) w_grant_pipe = 1'b1;
    else           w_grant_head = ~w_empty;
  end

  always_comb begin
    we      = w_grant_pipe | w_grant_head;
    wd_addr = '0;
    wd_data = '0;
    if (w_grant_head) begin
      wd_addr = w_head_addr;
      wd_data = w_head_data;
    end else if (w_grant_pipe) begin
      wd_addr = pipe_addr;
      wd_data = pipe_data;
    end
  end

  always_comb begin
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    w_pipe_hit  = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_entry_valid[i]) begin
        if (w_entry_addr[i*AW +: AW] == rs1_addr && rs1_addr != '0)   rs1_pending = 1'b1;
        if (w_entry_addr[i*AW +: AW] == rs2_addr && rs2_addr != '0)   rs2_pending = 1'b1;
        if (w_entry_addr[i*AW +: AW] == pipe_addr) w_pipe_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
`ifdef RF_WB_ARB_STARVE_EN
    w_starve_cnt_d = r_starve_cnt;
`endif
    case (r_state)
      ARB_IDLE: if (w_push) w_state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (w_last_pop) w_state_d = ARB_IDLE;
`ifdef RF_WB_ARB_STARVE_EN
        if (w_pop) begin
          w_starve_cnt_d = '0;
        end else if (r_starve_cnt != LimitCnt) begin
          w_starve_cnt_d = r_starve_cnt + 4'd1;
          if (w_starve_cnt_d == LimitCnt) w_state_d = ARB_STALL;
        end
`endif
      end
`ifdef RF_WB_ARB_STARVE_EN
      ARB_STALL: begin
        w_starve_cnt_d = '0;
        w_state_d      = w_last_pop ? ARB_IDLE : ARB_WAIT;
      end
`endif
      default: w_state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state   <= ARB_IDLE;
      r_waw_err <= 1'b0;
`ifdef RF_WB_ARB_STARVE_EN
      r_starve_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_waw_err <= r_waw_err | (w_grant_pipe & w_pipe_hit);
`ifdef RF_WB_ARB_STARVE_EN
      r_starve_cnt <= w_starve_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table, scoreboard model and corner sequences.
// Expectations follow RF_WB_ARB_STARVE_EN when it is defined for the build.
module tb_rf_wb_arbiter;

  localparam int unsigned Depth = 2;
  localparam int unsigned Limit = 4;
`ifdef RF_WB_ARB_STARVE_EN
  localparam bit StarveEn = 1'b1;
`else
  localparam bit StarveEn = 1'b0;
`endif

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_addr = '0;
  logic [31:0] pipe_data = '0;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [4:0]  mc_addr = '0;
  logic [31:0] mc_data = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_pending, rs2_pending, pipe_stall, we, waw_err;
  logic [4:0]  wd_addr;
  logic [31:0] wd_data;

  int checks = 0;
  int failures = 0;

  rf_wb_arbiter #(
    .REGISTER_WIDTH     (32),
    .REGISTER_ADDR_WIDTH(5),
    .FIFO_DEPTH         (Depth),
    .STARVE_LIMIT       (Limit)
  ) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .mc_valid   (mc_valid),
    .mc_ready   (mc_ready),
    .mc_addr    (mc_addr),
    .mc_data    (mc_data),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_pending(rs1_pending),
    .rs2_pending(rs2_pending),
    .pipe_stall (pipe_stall),
    .we         (we),
    .wd_addr    (wd_addr),
    .wd_data    (wd_data),
    .waw_err    (waw_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard model of the buffered results and forced-grant timing.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];
  int   m_cnt = 0;
  bit   m_stall = 1'b0;
  bit   m_waw = 1'b0;

  always @(negedge cpu_clk) begin : mon
    bit p1, p2, pwr, rdy;
    ent_t h;
    if (cpu_rst) begin
      q.delete();
      m_cnt = 0;
      m_stall = 1'b0;
      m_waw = 1'b0;
      chk("rst_ready", mc_ready, 1);
      chk("rst_stall", pipe_stall, 0);
      chk("rst_waw", waw_err, 0);
      chk("rst_pend", {rs1_pending, rs2_pending}, 0);
      chk("rst_we", we, pipe_we && pipe_addr != 0);
    end else begin
      p1 = 1'b0;
      p2 = 1'b0;
      foreach (q[i]) begin
        if (q[i].a == rs1_addr && rs1_addr != 0) p1 = 1'b1;
        if (q[i].a == rs2_addr && rs2_addr != 0) p2 = 1'b1;
      end
      chk("sb_pend1", rs1_pending, p1);
      chk("sb_pend2", rs2_pending, p2);
      chk("sb_waw", waw_err, m_waw);
      rdy = (q.size() < Depth);
      chk("sb_ready", mc_ready, rdy);
      chk("sb_stall", pipe_stall, m_stall);
      pwr = pipe_we && pipe_addr != 0;
      if (m_stall || (!pwr && q.size() > 0)) begin
        h = q.pop_front();
        chk("sb_we", we, 1);
        chk("sb_head_addr", wd_addr, h.a);
        chk("sb_head_data", wd_data, h.d);
        m_cnt = 0;
        m_stall = 1'b0;
      end else if (pwr) begin
        chk("sb_we", we, 1);
        chk("sb_pipe_addr", wd_addr, pipe_addr);
        chk("sb_pipe_data", wd_data, pipe_data);
        foreach (q[i]) if (q[i].a == pipe_addr) m_waw = 1'b1;
        if (StarveEn && q.size() > 0) begin
          m_cnt++;
          if (m_cnt == Limit) m_stall = 1'b1;
        end
      end else begin
        chk("sb_we", we, 0);
      end
      if (mc_valid && rdy && mc_addr != 0) q.push_back('{a: mc_addr, d: mc_data});
    end
  end

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    pipe_we = pwe;
    pipe_addr = pa;
    pipe_data = pd;
    mc_valid = mv;
    mc_addr = ma;
    mc_data = md;
  endtask

  task automatic next_cycle();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    cpu_rst = 1'b1;
    next_cycle();
    next_cycle();
    cpu_rst = 1'b0;
  endtask

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        erdy;
  } vec_t;

  vec_t vecs[13];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1, 9, 32'hA0, 0, 0, 0,      1, 9, 32'hA0, 1};
    vecs[1]  = '{1, 0, 32'hB0, 0, 0, 0,      0, 0, 0,      1};
    vecs[2]  = '{0, 0, 0,      1, 5, 32'h11, 0, 0, 0,      1};
    vecs[3]  = '{0, 0, 0,      0, 0, 0,      1, 5, 32'h11, 1};
    vecs[4]  = '{1, 2, 32'hC0, 1, 6, 32'h22, 1, 2, 32'hC0, 1};
    vecs[5]  = '{1, 3, 32'hD0, 1, 7, 32'h33, 1, 3, 32'hD0, 1};
    vecs[6]  = '{1, 4, 32'hE0, 1, 8, 32'h44, 1, 4, 32'hE0, 0};
    vecs[7]  = '{0, 0, 0,      1, 8, 32'h44, 1, 6, 32'h22, 0};
    vecs[8]  = '{0, 0, 0,      1, 8, 32'h44, 1, 7, 32'h33, 1};
    vecs[9]  = '{0, 0, 0,      0, 0, 0,      1, 8, 32'h44, 1};
    vecs[10] = '{0, 0, 0,      0, 0, 0,      0, 0, 0,      1};
    vecs[11] = '{0, 0, 0,      1, 0, 32'h55, 0, 0, 0,      1};
    vecs[12] = '{0, 0, 0,      0, 0, 0,      0, 0, 0,      1};

    // Reset state, and the immediate effect of pipe_we while held in reset.
    next_cycle();
    drive(1, 3, 32'h99, 0, 0, 0);
    @(negedge cpu_clk);
    chk("reset_we_pipe", {we, wd_addr}, {1'b1, 5'd3});
    chk("reset_ready", mc_ready, 1);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].mv, vecs[i].ma, vecs[i].md);
      @(negedge cpu_clk);
      chk($sformatf("vec%0d_we", i), we, vecs[i].ewe);
      if (vecs[i].ewe) begin
        chk($sformatf("vec%0d_addr", i), wd_addr, vecs[i].ea);
        chk($sformatf("vec%0d_data", i), wd_data, vecs[i].ed);
      end
      chk($sformatf("vec%0d_ready", i), mc_ready, vecs[i].erdy);
      next_cycle();
    end

    // Single result: written the cycle after acceptance, pending exactly one cycle.
    do_reset();
    rs1_addr = 5;
    drive(0, 0, 0, 1, 5, 32'h11);
    @(negedge cpu_clk);
    chk("s1_c0", {we, rs1_pending}, 2'b00);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge cpu_clk);
    chk("s1_c1", {we, wd_addr, wd_data, rs1_pending}, {1'b1, 5'd5, 32'h11, 1'b1});
    next_cycle();
    @(negedge cpu_clk);
    chk("s1_c2", {we, rs1_pending}, 2'b00);

    // Starvation under continuous pipeline writes.
    do_reset();
    for (int t = 0; t < 14; t++) begin
      bit st;
      logic [4:0] ea;
      drive(1, 10, 32'h1000 + t, t < 2, 5'(3 + t), 32'h300 + t);
      st = StarveEn && (t == 5 || t == 10);
      ea = !st ? 5'd10 : (t == 5 ? 5'd3 : 5'd4);
      @(negedge cpu_clk);
      chk($sformatf("starve_t%0d_stall", t), pipe_stall, st);
      chk($sformatf("starve_t%0d_addr", t), wd_addr, ea);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();

    // Ordering violation is sticky until reset.
    do_reset();
    drive(1, 1, 32'h1, 1, 7, 32'h77);
    next_cycle();
    drive(1, 7, 32'h2, 0, 0, 0);
    @(negedge cpu_clk);
    chk("waw_before", waw_err, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();
    @(negedge cpu_clk);
    chk("waw_sticky", waw_err, 1);
    do_reset();
    @(negedge cpu_clk);
    chk("waw_cleared", waw_err, 0);

    // Reset mid-cycle with two entries buffered: immediate effect, nothing written later.
    next_cycle();
    rs1_addr = 12;
    drive(1, 10, 32'hAA, 1, 12, 32'hC12);
    next_cycle();
    drive(1, 10, 32'hAB, 1, 13, 32'hC13);
    next_cycle();
    drive(1, 10, 32'hAC, 0, 0, 0);
    #2;
    cpu_rst = 1'b1;
    #1;
    chk("midrst_ready", mc_ready, 1);
    chk("midrst_pend", rs1_pending, 0);
    chk("midrst_stall", pipe_stall, 0);
    chk("midrst_we", {we, wd_addr}, {1'b1, 5'd10});
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    cpu_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge cpu_clk);
      chk($sformatf("postrst_we%0d", i), we, 0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
